opnd_buf: RTL and testbench

Parametrised operand buffer between the decode stage and the ALU, replacing the single-cycle operand A/B holding registers. It captures an operand pair (A, B) per accepted transfer into a DEPTH-entry FIFO. It presents the oldest pair to the ALU under a valid/ready handshake. It also provides synchronous flush for branch redirect, an occupancy count, and a sticky overflow error flag.

---
 rtl/opnd_buf.sv | 114 +++++++++++
 tb/tb_opnd_buf.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opnd_buf.sv
// Operand A/B FIFO between decode and ALU with flush, count and sticky overflow.
// Optional same-cycle empty bypass under `define OPBUF_BYPASS_EN.
module opnd_buf #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_a,
  output logic [WIDTH-1:0]         out_b,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] P_ONE = AW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [2*WIDTH-1:0] head;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic empty;
  logic byp;
  logic byp_take;
  logic push;
  logic pop;
  logic wr_en;
  logic rd_adv;

  assign empty    = (count_q == '0);
  assign in_ready = (count_q != C_FULL);
  assign count    = count_q;
  assign ovf_err  = ovf_q;

`ifdef OPBUF_BYPASS_EN
  assign byp = empty & in_valid & ~flush;
`else
  assign byp = 1'b0;
`endif

  assign out_valid = ~empty | byp;
  assign head      = mem_q[rd_ptr_q];

  always_comb begin
    out_a = '0;
    out_b = '0;
    if (!empty) begin
      out_a = head[2*WIDTH-1:WIDTH];
      out_b = head[WIDTH-1:0];
    end else if (byp) begin
      out_a = in_a;
      out_b = in_b;
    end
  end

  assign push     = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  // A bypassed pair taken by the ALU never touches storage
  assign byp_take = byp & out_ready;
  assign wr_en    = push & ~flush & ~byp_take;
  assign rd_adv   = pop & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end else begin
      if (in_valid && !in_ready) ovf_d = 1'b1;
      if (wr_en) wr_ptr_d = wr_ptr_q + P_ONE;
      if (rd_adv) rd_ptr_d = rd_ptr_q + P_ONE;
      if (wr_en && !rd_adv) count_d = count_q + C_ONE;
      else if (!wr_en && rd_adv) count_d = count_q - C_ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

endmodule

// File: tb/tb_opnd_buf.sv
// Self-checking bench for opnd_buf: queue-based reference model,
// directed scenarios plus randomized push/pop/flush traffic.
module tb_opnd_buf;

  localparam int W = 16;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_a;
  logic [W-1:0] out_b;
  logic [2:0]   count;
  logic         ovf_err;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [2*W-1:0] q[$];
  bit m_ovf = 1'b0;

  opnd_buf #(.WIDTH(W), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b),
    .count(count), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

`ifdef OPBUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic bit byp_now();
    return BYP && q.size() == 0 && in_valid && !flush;
  endfunction

  function automatic logic exp_valid();
    return (q.size() != 0) || byp_now();
  endfunction

  function automatic logic [W-1:0] exp_a();
    if (q.size() != 0) return q[0][2*W-1:W];
    if (byp_now()) return in_a;
    return '0;
  endfunction

  function automatic logic [W-1:0] exp_b();
    if (q.size() != 0) return q[0][W-1:0];
    if (byp_now()) return in_b;
    return '0;
  endfunction

  function automatic logic [2:0] exp_cnt();
    return 3'(q.size());
  endfunction

  function automatic logic exp_rdy();
    return q.size() < D;
  endfunction

  // Advance one clock, updating the model from the inputs now applied
  task automatic step();
    int sz;
    bit do_push;
    sz = q.size();
    if (flush) begin
      q.delete();
      m_ovf = 1'b0;
    end else begin
      do_push = in_valid && sz < D;
      if (in_valid && sz >= D) m_ovf = 1'b1;
      if (BYP && sz == 0 && in_valid && out_ready) do_push = 1'b0;
      if (out_ready && sz > 0) void'(q.pop_front());
      if (do_push) q.push_back({in_a, in_b});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    out_ready = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1'b1;
    in_a = 16'h1111; in_b = 16'h2222;
    step();
    in_a = 16'h3333; in_b = 16'h4444;
    step();
    idle();
    #1;
    total_cnt++;
    if (count !== 3'd2) $display("FAIL pre_rst_count got=%0d exp=2", count);
    else pass_cnt++;
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_ovf = 1'b0;
    total_cnt++;
    if (count !== 3'd0) $display("FAIL rst_count got=%0d exp=0", count);
    else pass_cnt++;
    total_cnt++;
    if (out_valid !== 1'b0) $display("FAIL rst_out_valid got=%b exp=0", out_valid);
    else pass_cnt++;
    total_cnt++;
    if (out_a !== '0 || out_b !== '0)
      $display("FAIL rst_out_data got=%h/%h exp=0/0", out_a, out_b);
    else pass_cnt++;
    total_cnt++;
    if (in_ready !== 1'b1 || ovf_err !== 1'b0)
      $display("FAIL rst_rdy_ovf got=%b/%b exp=1/0", in_ready, ovf_err);
    else pass_cnt++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b1;
    in_a = 16'h1234; in_b = 16'hABCD;
    #1;
    total_cnt++;
    if (out_valid !== exp_valid())
      $display("FAIL single_same_cycle_valid got=%b exp=%b", out_valid, exp_valid());
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total_cnt++;
      if (out_valid !== 1'b1 || out_a !== 16'h1234 || out_b !== 16'hABCD)
        $display("FAIL single_hold[%0d] got=%b %h/%h exp=1 1234/abcd",
                 i, out_valid, out_a, out_b);
      else pass_cnt++;
      if (i < 3) step();
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_fill_ovf();
    idle();
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_valid = 1'b1;
      in_a = 16'(i); in_b = 16'(i + 100);
      step();
      if (i == 4) begin
        total_cnt++;
        if (in_ready !== 1'b0 || count !== 3'd4 || ovf_err !== 1'b0)
          $display("FAIL fill4 got rdy=%b cnt=%0d ovf=%b exp 0/4/0",
                   in_ready, count, ovf_err);
        else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    #1;
    total_cnt++;
    if (ovf_err !== 1'b1 || count !== 3'd4)
      $display("FAIL ovf_set got ovf=%b cnt=%0d exp 1/4", ovf_err, count);
    else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total_cnt++;
      if (out_valid !== 1'b1 || out_a !== 16'(i) || out_b !== 16'(i + 100))
        $display("FAIL drain[%0d] got=%b %h/%h exp=1 %h/%h",
                 i, out_valid, out_a, out_b, 16'(i), 16'(i + 100));
      else pass_cnt++;
      step();
    end
    #1;
    total_cnt++;
    if (out_valid !== 1'b0 || count !== 3'd0)
      $display("FAIL drain_empty got valid=%b cnt=%0d exp 0/0", out_valid, count);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_simul();
    idle();
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b1;
    in_a = 16'd5; in_b = 16'd55; step();
    in_a = 16'd6; in_b = 16'd66; step();
    in_a = 16'd7; in_b = 16'd77;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (out_a !== 16'd5) $display("FAIL simul_head0 got=%h exp=5", out_a);
    else pass_cnt++;
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    total_cnt++;
    if (count !== 3'd2 || out_a !== 16'd6)
      $display("FAIL simul_after got cnt=%0d a=%h exp 2/6", count, out_a);
    else pass_cnt++;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (out_a !== 16'd7 || out_b !== 16'd77)
      $display("FAIL simul_tail got=%h/%h exp=7/77", out_a, out_b);
    else pass_cnt++;
    step();
    idle();
  endtask

  task automatic test_flush();
    idle();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 16'(i + 40); in_b = 16'(i + 80);
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    total_cnt++;
    if (count !== 3'd3 || ovf_err !== 1'b1)
      $display("FAIL flush_pre got cnt=%0d ovf=%b exp 3/1", count, ovf_err);
    else pass_cnt++;
    in_valid = 1'b1;
    in_a = 16'h00AA; in_b = 16'h00BB;
    flush = 1'b1;
    step();
    idle();
    #1;
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0 || ovf_err !== 1'b0)
      $display("FAIL flush_post got cnt=%0d valid=%b ovf=%b exp 0/0/0",
               count, out_valid, ovf_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (count !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL flush_not_stored got cnt=%0d valid=%b exp 0/0", count, out_valid);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    idle();
    in_valid = 1'b1;
    in_a = 16'd9; in_b = 16'd99;
    out_ready = 1'b1;
    #1;
    total_cnt++;
    if (out_valid !== BYP)
      $display("FAIL byp_valid got=%b exp=%b", out_valid, BYP);
    else pass_cnt++;
    if (BYP) begin
      total_cnt++;
      if (out_a !== 16'd9) $display("FAIL byp_a got=%h exp=9", out_a);
      else pass_cnt++;
    end
    step();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    if (BYP) begin
      total_cnt++;
      if (count !== 3'd0 || out_valid !== 1'b0)
        $display("FAIL byp_after got cnt=%0d valid=%b exp 0/0", count, out_valid);
      else pass_cnt++;
    end else begin
      total_cnt++;
      if (out_valid !== 1'b1 || out_a !== 16'd9 || count !== 3'd1)
        $display("FAIL nobyp_after got valid=%b a=%h cnt=%0d exp 1/9/1",
                 out_valid, out_a, count);
      else pass_cnt++;
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    for (int n = 0; n < 300; n++) begin
      in_valid = ($urandom_range(0, 9) < 6);
      in_a = 16'($urandom);
      in_b = 16'($urandom);
      out_ready = ($urandom_range(0, 9) < 5);
      flush = ($urandom_range(0, 29) == 0);
      #1;
      total_cnt++;
      if (out_valid !== exp_valid() || out_a !== exp_a() || out_b !== exp_b())
        $display("FAIL rand_out[%0d] got=%b %h/%h exp=%b %h/%h", n,
                 out_valid, out_a, out_b, exp_valid(), exp_a(), exp_b());
      else pass_cnt++;
      total_cnt++;
      if (count !== exp_cnt() || in_ready !== exp_rdy() || ovf_err !== m_ovf)
        $display("FAIL rand_state[%0d] got cnt=%0d rdy=%b ovf=%b exp %0d/%b/%b",
                 n, count, in_ready, ovf_err, exp_cnt(), exp_rdy(), m_ovf);
      else pass_cnt++;
      step();
    end
    idle();
  endtask

  initial begin
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_reset();
    test_fill_ovf();
    test_simul();
    test_flush();
    test_bypass();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
